// File: rtl/batcharger_status_tx_pkg.sv
// -----------------------------------------------------------------------------
// batcharger_pkg
// Shared types and constants for the battery-charger status transmitter.
//
// Contents:
//   - TYPE_W / DATA_W  : widths of the frame type and payload fields
//   - TYPE_*           : frame type codes used by the charger core
//   - tx_state_e       : serialiser state encoding
//   - frame_bits()     : total bits on the wire for a given stop-bit count
//
// Build option: BATCHARGER_STATUS_TX_PARITY_EN adds the PARITY state and
// lengthens the frame by one bit.
// -----------------------------------------------------------------------------
package batcharger_pkg;

    localparam int TYPE_W = 4;
    localparam int DATA_W = 8;

    localparam logic [TYPE_W-1:0] TYPE_MODE = 4'h1;
    localparam logic [TYPE_W-1:0] TYPE_VBAT = 4'h2;
    localparam logic [TYPE_W-1:0] TYPE_TEMP = 4'h3;
    localparam logic [TYPE_W-1:0] TYPE_SEL  = 4'h4;

    // state  | meaning
    // IDLE   | line high, waiting for a frame (s_ready when en)
    // START  | start bit (0)
    // TYPE   | type[3:0], LSB first
    // DATA   | data[7:0], LSB first
    // PARITY | even parity over type and data (parity build only)
    // STOP   | STOP_BITS stop bits (1)
    typedef enum logic [2:0] {
        IDLE,
        START,
        TYPE,
        DATA,
`ifdef BATCHARGER_STATUS_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_e;

`ifdef BATCHARGER_STATUS_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Start + type + data + optional parity + stop bits.
    function automatic int frame_bits(input int stop_bits);
        return 1 + TYPE_W + DATA_W + PARITY_BITS + stop_bits;
    endfunction

endpackage

// File: rtl/batcharger_status_tx_if.sv
// -----------------------------------------------------------------------------
// batcharger_status_tx_if
// Valid/ready frame handshake between the charger core and the status
// transmitter.
//
// Signals:
//   s_valid  core -> tx   frame request, held until accepted
//   s_ready  tx -> core   transmitter can accept a frame this cycle
//   s_type   core -> tx   4-bit frame type, sampled on accept
//   s_data   core -> tx   8-bit payload, sampled on accept
//
// Modports: master (core side), slave (transmitter side).
// -----------------------------------------------------------------------------
interface batcharger_status_tx_if;
    import batcharger_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [TYPE_W-1:0] s_type;
    logic [DATA_W-1:0] s_data;

    modport master (
        output s_valid,
        output s_type,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_type,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/batcharger_status_tx_baud_gen.sv
// -----------------------------------------------------------------------------
// batcharger_baud_gen
// Bit-period timer for the status transmitter. Counts 0..CLK_DIV-1 while
// run is high and wraps; held at 0 while idle, on clr and on rst so each
// frame's start bit is a full CLK_DIV cycles.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   clr          restart the bit period (frame accept)
//   run          a frame is on the wire
//   bit_tick     1-cycle pulse in the last cycle of a bit period
//   bit_pre_tick 1-cycle pulse in the next-to-last cycle of a bit period
//
// Parameters: CLK_DIV (2..255) clk cycles per bit.
// -----------------------------------------------------------------------------
module batcharger_baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic bit_tick,
    output logic bit_pre_tick
);

    localparam logic [7:0] TC     = 8'(CLK_DIV - 1);
    localparam logic [7:0] PRE_TC = 8'(CLK_DIV - 2);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr || !run) begin
            cnt <= '0;
        end else if (cnt == TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign bit_tick     = run && (cnt == TC);
    assign bit_pre_tick = run && (cnt == PRE_TC);

endmodule

// File: rtl/batcharger_status_tx.sv
// -----------------------------------------------------------------------------
// batcharger_status_tx
// Core-to-pad serial status transmitter. Accepts one frame (type + payload)
// over a valid/ready handshake and shifts it out LSB first:
//   start(0), type[3:0], data[7:0], [parity], STOP_BITS x stop(1)
// Each bit lasts CLK_DIV clk cycles. The line idles high.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   en         block enable; gates new frames, mirrored onto tx_oe
//   bus        frame handshake (slave modport of batcharger_status_tx_if)
//   tx         serial output to the pad
//   tx_oe      pad output enable, en delayed by one cycle
//   busy       frame in progress
//   frame_cnt  completed frames, wraps 255 -> 0
//
// Parameters: CLK_DIV (2..255), STOP_BITS (1 or 2).
// Build option: BATCHARGER_STATUS_TX_PARITY_EN inserts an even-parity bit
// over type and data after the payload.
// -----------------------------------------------------------------------------
module batcharger_status_tx
    import batcharger_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    batcharger_status_tx_if.slave        bus,
    output logic                         tx,
    output logic                         tx_oe,
    output logic                         busy,
    output logic [7:0]                   frame_cnt
);

    localparam logic [2:0] TYPE_LAST = 3'(TYPE_W - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_W - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_e                  state;
    logic [TYPE_W+DATA_W-1:0]   shreg;
    logic [2:0]                 bit_cnt;
    logic                       accept;
    logic                       bit_tick;
    logic                       bit_pre_tick;
`ifdef BATCHARGER_STATUS_TX_PARITY_EN
    logic                       parity_bit;
`endif

    assign bus.s_ready = (state == IDLE) && en && !rst;
    assign accept      = bus.s_valid && bus.s_ready;

    batcharger_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .clk          (clk),
        .rst          (rst),
        .clr          (accept),
        .run          (state != IDLE),
        .bit_tick     (bit_tick),
        .bit_pre_tick (bit_pre_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b1;
            tx_oe     <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
`ifdef BATCHARGER_STATUS_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_oe <= en;

            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= {bus.s_data, bus.s_type};
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
`ifdef BATCHARGER_STATUS_TX_PARITY_EN
                        parity_bit <= ^{bus.s_type, bus.s_data};
`endif
                    end
                end

                START: begin
                    if (bit_tick) begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= TYPE;
                    end
                end

                // The last type tick already presents data[0]: type and data
                // sit contiguously in the shift register.
                TYPE: begin
                    if (bit_tick) begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                        if (bit_cnt == TYPE_LAST) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef BATCHARGER_STATUS_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

`ifdef BATCHARGER_STATUS_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif

                // The last stop bit hands over to IDLE one cycle early: the
                // IDLE cycle itself is the final (high) cycle of that bit, so
                // a frame accepted there starts with no gap and every bit
                // still lasts exactly CLK_DIV cycles.
                STOP: begin
                    if ((bit_cnt == STOP_LAST) && bit_pre_tick) begin
                        bit_cnt   <= '0;
                        busy      <= 1'b0;
                        frame_cnt <= frame_cnt + 8'd1;
                        state     <= IDLE;
                    end else if (bit_tick) begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_batcharger_status_tx.sv
module tb_batcharger_status_tx;
    import batcharger_pkg::*;

    localparam int DIV = 4;
`ifdef BATCHARGER_STATUS_TX_PARITY_EN
    localparam int CORE_BITS = 14;
`else
    localparam int CORE_BITS = 13;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       tx1, oe1, busy1;
    logic [7:0] cnt1;
    logic       tx2, oe2, busy2;
    logic [7:0] cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    batcharger_status_tx_if if1 ();
    batcharger_status_tx_if if2 ();

    batcharger_status_tx #(.CLK_DIV(DIV), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .bus(if1),
        .tx(tx1), .tx_oe(oe1), .busy(busy1), .frame_cnt(cnt1)
    );

    batcharger_status_tx #(.CLK_DIV(DIV), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .bus(if2),
        .tx(tx2), .tx_oe(oe2), .busy(busy2), .frame_cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send1(input logic [3:0] t, input logic [7:0] d);
        if1.s_type  = t;
        if1.s_data  = d;
        if1.s_valid = 1'b1;
        #1;
        chk("accept_ready", 32'(if1.s_ready), 32'(1));
        @(negedge clk);
        if1.s_valid = 1'b0;
    endtask

    // Called at the negedge of the first cycle of a frame; returns at the
    // negedge of the first cycle after the frame. en is dropped after the
    // checks of cycle drop_at (-1: never).
    task automatic check_frame(input logic [3:0] t, input logic [7:0] d,
                               input int drop_at, input string tag);
        logic [15:0] bits;
        int          nb;
        int          total;
        int          k;
        bits     = '0;
        bits[4:1]  = t;
        bits[12:5] = d;
        nb = 13;
`ifdef BATCHARGER_STATUS_TX_PARITY_EN
        bits[13] = ^{t, d};
        nb = 14;
`endif
        bits[nb[3:0]] = 1'b1;
        nb = nb + 1;
        total = nb * DIV;
        k = 0;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < DIV; c++) begin
                chk({tag, "_tx"}, 32'(tx1), 32'(bits[i[3:0]]));
                chk({tag, "_busy"}, 32'(busy1), (k == total - 1) ? 32'(0) : 32'(1));
                chk({tag, "_ready"}, 32'(if1.s_ready), (k == total - 1) ? 32'(en) : 32'(0));
                chk({tag, "_oe"}, 32'(oe1), 32'(en));
                if (k == drop_at) en = 1'b0;
                k++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int w;
        rst = 1'b1;
        en  = 1'b0;
        if1.s_valid = 1'b0; if1.s_type = '0; if1.s_data = '0;
        if2.s_valid = 1'b0; if2.s_type = '0; if2.s_data = '0;

        // Reset defaults and en -> tx_oe / s_ready
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(tx1), 32'(1));
        chk("rst_oe", 32'(oe1), 32'(0));
        chk("rst_busy", 32'(busy1), 32'(0));
        chk("rst_cnt", 32'(cnt1), 32'(0));
        chk("rst_ready", 32'(if1.s_ready), 32'(0));
        en = 1'b1;
        #1;
        chk("rst_ready_en", 32'(if1.s_ready), 32'(0));
        en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        #1;
        chk("en_ready", 32'(if1.s_ready), 32'(1));
        chk("en_oe_lag", 32'(oe1), 32'(0));
        @(negedge clk);
        chk("en_oe", 32'(oe1), 32'(1));

        // Reset during DATA bit 3 (frame bit 8); data[3]=0 so the line is low
        send1(TYPE_VBAT, 8'h34);
        repeat (34) @(negedge clk);
        chk("mid_tx_pre", 32'(tx1), 32'(0));
        chk("mid_busy_pre", 32'(busy1), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_tx", 32'(tx1), 32'(1));
        chk("mid_busy", 32'(busy1), 32'(0));
        chk("mid_cnt", 32'(cnt1), 32'(0));
        chk("mid_oe", 32'(oe1), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("mid_oe_back", 32'(oe1), 32'(1));
        chk("mid_ready_back", 32'(if1.s_ready), 32'(1));

        // Basic frame 0x5 / 0xA7
        send1(4'h5, 8'hA7);
        check_frame(4'h5, 8'hA7, -1, "basic");
        chk("basic_busy_end", 32'(busy1), 32'(0));
        chk("basic_tx_idle", 32'(tx1), 32'(1));
        chk("basic_cnt", 32'(cnt1), 32'(1));

        // Back-to-back: second frame accepted in the first IDLE cycle
        if1.s_type  = TYPE_MODE;
        if1.s_data  = 8'h0F;
        if1.s_valid = 1'b1;
        #1;
        chk("b2b_ready", 32'(if1.s_ready), 32'(1));
        @(negedge clk);
        if1.s_type = TYPE_SEL;
        if1.s_data = 8'hC3;
        check_frame(TYPE_MODE, 8'h0F, -1, "b2b_a");
        if1.s_valid = 1'b0;
        check_frame(TYPE_SEL, 8'hC3, -1, "b2b_b");
        chk("b2b_cnt", 32'(cnt1), 32'(3));
        chk("b2b_busy_end", 32'(busy1), 32'(0));

        // en dropped mid-frame: frame completes, pad tristates, no new accept
        send1(TYPE_TEMP, 8'h5A);
        check_frame(TYPE_TEMP, 8'h5A, 20, "endrop");
        chk("endrop_cnt", 32'(cnt1), 32'(4));
        chk("endrop_tx", 32'(tx1), 32'(1));
        if1.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("endrop_hold_ready", 32'(if1.s_ready), 32'(0));
            chk("endrop_hold_busy", 32'(busy1), 32'(0));
            @(negedge clk);
        end
        chk("endrop_hold_cnt", 32'(cnt1), 32'(4));
        if1.s_valid = 1'b0;
        en = 1'b1;
        @(negedge clk);

        // Frame counter wrap: stream frames back to back
        if1.s_type  = TYPE_VBAT;
        if1.s_data  = 8'h80;
        if1.s_valid = 1'b1;
        w = 0;
        while (cnt1 !== 8'hFF && w < 20000) begin
            @(negedge clk);
            w++;
        end
        chk("wrap_255", 32'(cnt1), 32'(8'hFF));
        w = 0;
        while (cnt1 !== 8'h00 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if1.s_valid = 1'b0;
        chk("wrap_0", 32'(cnt1), 32'(0));
        chk("wrap_gap", 32'(w), 32'(CORE_BITS + 1) * DIV);
        @(negedge clk);
        chk("wrap_busy", 32'(busy1), 32'(0));
        chk("wrap_cnt_hold", 32'(cnt1), 32'(0));

        // Two stop bits: frame length in cycles
        if2.s_type  = TYPE_MODE;
        if2.s_data  = 8'h55;
        if2.s_valid = 1'b1;
        #1;
        chk("stop2_ready", 32'(if2.s_ready), 32'(1));
        @(negedge clk);
        if2.s_valid = 1'b0;
        chk("stop2_start", 32'(tx2), 32'(0));
        chk("stop2_busy", 32'(busy2), 32'(1));
        w = 1;
        while (!if2.s_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("stop2_len", 32'(w), 32'((CORE_BITS + 2) * DIV));
        chk("stop2_tx_end", 32'(tx2), 32'(1));
        chk("stop2_busy_end", 32'(busy2), 32'(0));
        chk("stop2_cnt", 32'(cnt2), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/batcharger_status_tx.md
Name: batcharger_status_tx

Overview:
Serial status transmitter for the battery-charger chip. It is the core-to-pad direction of the pad ring. The charger core hands it one status frame at a time: a 4-bit frame type plus an 8-bit payload (charger mode, VBAT code, temperature code, sel readback). The block serialises each frame onto a single digital output pad and drives that pad's output-enable.

Parameters:
- CLK_DIV, 16, clk cycles per bit; legal range 2..255.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  block enable; mirrors the chip en pin after the core.
- s_valid  input  1  frame request from the core.
- s_ready  output  1  block can accept a frame this cycle.
- s_type  input  4  frame type; sampled on accept.
- s_data  input  8  payload; sampled on accept.
- tx  output  1  serial line to the output pad; idles high.
- tx_oe  output  1  pad output enable.
- busy  output  1  frame in progress.
- frame_cnt  output  8  count of completed frames; wraps at 255 to 0.

Behaviour:
- Reset values: tx=1, tx_oe=0, busy=0, s_ready=0, frame_cnt=0. State is IDLE. Baud and bit counters are 0.
- Reset mid-frame: on the next edge tx=1, busy=0, the frame is discarded and frame_cnt is unchanged.
- tx_oe is a registered copy of en, so it lags en by 1 cycle.
- s_ready = (state==IDLE) & en & ~rst. This is combinational from registered state.
- A frame is accepted on any cycle with s_valid & s_ready. s_type and s_data are latched into a shift register. s_valid held high while s_ready=0 is ignored and no frame is lost silently. The core must hold s_valid until it is accepted.
- Latency: tx falls (start bit) on the cycle after accept. busy rises on the same cycle.
- Frame order, every bit LSB first:
  - start bit (0)
  - type[3:0]
  - data[7:0]
  - optional parity bit
  - STOP_BITS stop bits (1)
- Each bit lasts exactly CLK_DIV cycles.
- States: IDLE, START, TYPE, DATA, PARITY (feature only), STOP.
  - IDLE -> START on accept.
  - START -> TYPE after 1 bit.
  - TYPE -> DATA after 4 bits.
  - DATA -> PARITY or STOP after 8 bits.
  - PARITY -> STOP after 1 bit.
  - STOP -> IDLE after STOP_BITS bits.
- On the STOP->IDLE edge: busy falls and frame_cnt increments, wrapping 255 -> 0.
- Back-to-back frames: s_ready is high in the first IDLE cycle. If s_valid is high then, the next start bit follows with zero idle gap.
- en falling mid-frame: the current frame completes normally, then the block stays in IDLE with s_ready=0. tx_oe follows en regardless, so the pad tristates mid-frame. This is intentional, for fast pad shutdown.
- en low has no effect on frame_cnt.

Optional Feature:
- Macro: BATCHARGER_STATUS_TX_PARITY_EN.
- Defined: a PARITY bit is sent after data, equal to the XOR of type[3:0] and data[7:0] (even parity over 12 bits). Frame length is 14+STOP_BITS bits.
- Undefined: no PARITY state and no parity logic. Frame length is 13+STOP_BITS bits.

Decomposition:
- Package batcharger_pkg holds:
  - the tx state enum;
  - frame type constants: TYPE_MODE=4'h1, TYPE_VBAT=4'h2, TYPE_TEMP=4'h3, TYPE_SEL=4'h4;
  - widths TYPE_W=4 and DATA_W=8.
- Sub-module batcharger_baud_gen: a CLK_DIV counter producing a 1-cycle bit_tick.
  - Cleared on accept and on rst, so every frame's start bit is exactly CLK_DIV cycles.

Test Plan:
1. Reset defaults: after rst, tx=1, tx_oe=0, busy=0, frame_cnt=0. Then en=1 -> tx_oe=1 one cycle later and s_ready=1.
2. Basic frame, parity on, CLK_DIV=4, STOP_BITS=1: accept type=0x5, data=0xA7.
   - tx, one bit per 4 cycles: 0, 1,0,1,0, 1,1,1,0,0,1,0,1, 1 (parity), 1 (stop).
   - 60 cycles total; busy drops and frame_cnt=1.
3. Back-to-back: hold s_valid with two frames queued -> the second start bit begins on the cycle after the first stop bit ends, with no extra idle cycle.
4. Reset mid-frame: assert rst during the DATA bit 3 -> tx=1 and busy=0 next cycle, frame_cnt unchanged. A subsequent frame transmits correctly.
5. en dropped mid-frame: the frame finishes on tx and frame_cnt increments. tx_oe=0 one cycle after en falls. s_ready stays 0 while en=0.
6. Wrap and no-parity build: send 256 frames -> frame_cnt returns to 0. With the macro undefined and STOP_BITS=2, the frame is 15 bits × CLK_DIV cycles.
